apb_cmd_master: RTL and testbench

//  APB3 initiator. Converts one-at-a-time register commands from a valid/ready

---
 rtl/apb_cmd_master_if.sv | 36 +++
 rtl/apb_cmd_master.sv | 77 +++++++
 tb/tb_apb_cmd_master.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response handshake and APB3 bus bundle for apb_cmd_master
interface apb_cmd_master_if;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic        cmd_write_in;
    logic [31:0] cmd_addr_in;
    logic [31:0] cmd_wdata_in;
    logic        rsp_valid_out;
    logic        rsp_ready_in;
    logic [31:0] rsp_rdata_out;
    logic        rsp_err_out;
    logic        rsp_timeout_out;
    logic        busy_out;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, rsp_ready_in,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out, rsp_timeout_out,
               busy_out, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, rsp_ready_in,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out, rsp_timeout_out,
               busy_out, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB3 initiator turning single register commands into setup/access transfers
module apb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic               clk,
    input logic               rst_n,
    apb_cmd_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state, state_nx;
    logic [31:0] cnt;
    logic        accept, misaligned, done, abort;

    assign accept     = state == IDLE && bus.cmd_valid_in;
    assign misaligned = bus.cmd_addr_in[1:0] != 2'b00;
    assign done       = state == ACCESS && bus.PREADY;
    assign abort      = state == ACCESS && !bus.PREADY && TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_CYCLES - 1;

    assign bus.PSEL          = state == SETUP || state == ACCESS;
    assign bus.PENABLE       = state == ACCESS;
    assign bus.cmd_ready_out = state == IDLE;
    assign bus.rsp_valid_out = state == RESP;
    assign bus.busy_out      = state != IDLE;

    // Next-state decode; misaligned commands skip the bus entirely
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.cmd_valid_in) state_nx = misaligned ? RESP : SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (bus.PREADY || abort) state_nx = RESP;
            RESP:    if (bus.rsp_ready_in) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end

    // Request latch, wait-state counter and response capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.PADDR           <= '0;
            bus.PWDATA          <= '0;
            bus.PWRITE          <= 1'b0;
            bus.rsp_rdata_out   <= '0;
            bus.rsp_err_out     <= 1'b0;
            bus.rsp_timeout_out <= 1'b0;
            cnt                 <= '0;
        end else begin
            if (accept && !misaligned) begin
                bus.PADDR  <= bus.cmd_addr_in;
                bus.PWRITE <= bus.cmd_write_in;
                bus.PWDATA <= bus.cmd_write_in ? bus.cmd_wdata_in : '0;
            end
            cnt <= state == ACCESS ? cnt + 32'd1 : '0;
            if (accept && misaligned) begin
                bus.rsp_rdata_out   <= '0;
                bus.rsp_err_out     <= 1'b1;
                bus.rsp_timeout_out <= 1'b0;
            end
            if (done) begin
                bus.rsp_rdata_out   <= bus.PWRITE ? '0 : bus.PRDATA;
                bus.rsp_err_out     <= bus.PSLVERR;
                bus.rsp_timeout_out <= 1'b0;
            end
            if (abort) begin
                bus.rsp_rdata_out   <= '0;
                bus.rsp_err_out     <= 1'b1;
                bus.rsp_timeout_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table-driven scoreboard bench for apb_cmd_master
module tb_apb_cmd_master;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          waits;
        int          len;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    rsp_t sb[$];
    vec_t vecs[7];

    apb_cmd_master_if bif();

    apb_cmd_master dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int idx, input vec_t v);
        rsp_t        e;
        int          cyc;
        logic        stable;
        logic [31:0] r_rdata;
        logic        r_err, r_to;
        sb.push_back('{v.exp_rdata, v.exp_err, v.exp_to});
        bif.cmd_valid_in = 1'b1;
        bif.cmd_write_in = v.wr;
        bif.cmd_addr_in  = v.addr;
        bif.cmd_wdata_in = v.wdata;
        chk($sformatf("v%0d_cmd_ready", idx), {31'd0, bif.cmd_ready_out}, 32'd1);
        tick();
        bif.cmd_write_in = ~v.wr;
        bif.cmd_addr_in  = 32'hFFFF_FFF0;
        bif.cmd_wdata_in = 32'h0BAD_0BAD;
        if (v.len == 0) begin
            chk($sformatf("v%0d_no_psel", idx), {30'd0, bif.PSEL, bif.PENABLE}, 32'd0);
        end else begin
            chk($sformatf("v%0d_setup", idx), {30'd0, bif.PSEL, bif.PENABLE}, 32'd2);
            chk($sformatf("v%0d_setup_paddr", idx), bif.PADDR, v.addr);
            tick();
            cyc = 0;
            stable = 1'b1;
            while (bif.PSEL && cyc < 200) begin
                if (!bif.PENABLE || bif.PADDR !== v.addr || bif.PWRITE !== v.wr ||
                    bif.PWDATA !== (v.wr ? v.wdata : 32'd0) || !bif.busy_out || bif.cmd_ready_out)
                    stable = 1'b0;
                bif.PREADY  = cyc == v.waits;
                bif.PRDATA  = v.prdata;
                bif.PSLVERR = v.slverr;
                tick();
                cyc++;
            end
            bif.PREADY  = 1'b0;
            bif.PRDATA  = 32'hFEED_FACE;
            bif.PSLVERR = 1'b0;
            chk($sformatf("v%0d_access_len", idx), cyc, v.len);
            chk($sformatf("v%0d_access_stable", idx), {31'd0, stable}, 32'd1);
        end
        chk($sformatf("v%0d_rsp_valid", idx), {31'd0, bif.rsp_valid_out}, 32'd1);
        r_rdata = bif.rsp_rdata_out;
        r_err   = bif.rsp_err_out;
        r_to    = bif.rsp_timeout_out;
        if (v.hold > 0) begin
            stable = 1'b1;
            repeat (v.hold) begin
                tick();
                if (!bif.rsp_valid_out || bif.cmd_ready_out || bif.rsp_rdata_out !== r_rdata ||
                    bif.rsp_err_out !== r_err || bif.rsp_timeout_out !== r_to)
                    stable = 1'b0;
            end
            chk($sformatf("v%0d_rsp_hold", idx), {31'd0, stable}, 32'd1);
        end
        bif.cmd_valid_in = 1'b0;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_rdata", idx), bif.rsp_rdata_out, e.rdata);
            chk($sformatf("v%0d_err", idx), {31'd0, bif.rsp_err_out}, {31'd0, e.err});
            chk($sformatf("v%0d_timeout", idx), {31'd0, bif.rsp_timeout_out}, {31'd0, e.to});
        end
        bif.rsp_ready_in = 1'b1;
        tick();
        bif.rsp_ready_in = 1'b0;
        chk($sformatf("v%0d_rsp_done", idx), {30'd0, bif.rsp_valid_out, bif.cmd_ready_out}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             wr    addr           wdata          prdata         serr  wt    len hold exp_rdata      err   to
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0,         1'b0, 0,    1,  0,   32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, 1'b0, 3,    4,  0,   32'h1234_5678, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 1'b1, 1,    2,  0,   32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,         32'h1111_2222, 1'b0, 1000, 64, 0,   32'h0,         1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0013, 32'h7777_7777, 32'h0,         1'b0, 0,    0,  5,   32'h0,         1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0040, 32'h0102_0304, 32'h5555_5555, 1'b1, 2,    3,  0,   32'h0,         1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 1'b0, 0,    1,  2,   32'hCAFE_F00D, 1'b0, 1'b0};
        bif.cmd_valid_in = 1'b0;
        bif.cmd_write_in = 1'b0;
        bif.cmd_addr_in  = '0;
        bif.cmd_wdata_in = '0;
        bif.rsp_ready_in = 1'b0;
        bif.PRDATA       = '0;
        bif.PREADY       = 1'b0;
        bif.PSLVERR      = 1'b0;
        repeat (3) tick();
        chk("rst_psel_penable", {30'd0, bif.PSEL, bif.PENABLE}, 32'd0);
        chk("rst_paddr", bif.PADDR, 32'd0);
        chk("rst_pwdata", bif.PWDATA, 32'd0);
        chk("rst_rsp", {29'd0, bif.rsp_valid_out, bif.rsp_err_out, bif.rsp_timeout_out}, 32'd0);
        chk("rst_rdata", bif.rsp_rdata_out, 32'd0);
        chk("rst_busy", {31'd0, bif.busy_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", {31'd0, bif.cmd_ready_out}, 32'd1);

        for (int i = 0; i < 7; i++) run(i, vecs[i]);

        bif.cmd_valid_in = 1'b1;
        bif.cmd_write_in = 1'b1;
        bif.cmd_addr_in  = 32'h0000_0050;
        bif.cmd_wdata_in = 32'h9999_0000;
        tick();
        bif.cmd_valid_in = 1'b0;
        tick();
        chk("mid_rst_in_access", {30'd0, bif.PSEL, bif.PENABLE}, 32'd3);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_psel_penable", {30'd0, bif.PSEL, bif.PENABLE}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, bif.rsp_valid_out}, 32'd0);
        chk("mid_rst_paddr", bif.PADDR, 32'd0);
        rst_n = 1'b1;
        tick();
        run(7, '{1'b1, 32'h0000_0058, 32'h600D_600D, 32'h0, 1'b0, 1, 2, 0, 32'h0, 1'b0, 1'b0});

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
